// File: rtl/prng_range.sv
// Bounded random-number front end for an external 32-bit prng. Uses rejection sampling
// against the largest multiple of N below 2^31, then a shared restoring divider for the reduction.
module prng_range #(
    parameter logic [31:0] SEED_INIT = 32'h68493A1B,
    parameter int          MAX_TRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [30:0] bound,
    input  logic        seed_load,
    input  logic [31:0] seed_in,
    output logic        busy,
    output logic [30:0] val,
    output logic        val_valid,
    input  logic        val_ready,
    output logic        val_biased,
    output logic        err,
    output logic        prng_start,
    output logic [31:0] prng_seed,
    input  logic        prng_done,
    input  logic [31:0] prng_rand
);

    localparam int               TRY_W    = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRIES);
    localparam logic [30:0]      RAND_MAX = '1;
    localparam logic [4:0]       DIV_LAST = 5'd30;

    typedef enum logic [2:0] {
        IDLE,
        LIMIT,
        GEN_REQ,
        GEN_WAIT,
        CHECK,
        REDUCE,
        OUT
    } state_t;

    state_t           state, state_nxt;
    logic             rst_meta, rst_sync;
    logic [TRY_W-1:0] tries_q;
    logic [4:0]       div_cnt;
    logic [31:0]      seed_q;
    logic [30:0]      val_q;
    logic             biased_q;
    logic             err_q;

    logic [30:0]      n_q;
    logic [30:0]      limit_q;
    logic [30:0]      r_q;
    logic [30:0]      dvd_q;
    logic [30:0]      rem_q;
    logic [30:0]      rem_nxt;

    logic             accept;
    logic             div_active;
    logic             div_last;
    logic             capture;
    logic             accepted_draw;

    // One restoring-division step: shift in the next dividend bit, subtract N if it fits.
    function automatic logic [30:0] div_step(input logic [30:0] rem,
                                             input logic        bit_in,
                                             input logic [30:0] divisor);
        logic [31:0] trial;
        trial = {rem, bit_in};
        if (trial >= {1'b0, divisor})
            trial = trial - {1'b0, divisor};
        return trial[30:0];
    endfunction

    // Assertion is immediate, release is retimed through two flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    assign accept        = (state == IDLE) && req && (bound != '0);
    assign div_active    = (state == LIMIT) || (state == REDUCE);
    assign div_last      = div_active && (div_cnt == DIV_LAST);
    assign capture       = (state == GEN_WAIT) && !prng_done;
    assign accepted_draw = (r_q < limit_q);
    assign rem_nxt       = div_step(rem_q, dvd_q[30], n_q);

    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = LIMIT;
            LIMIT:    if (div_last) state_nxt = GEN_REQ;
            GEN_REQ:  if (prng_done) state_nxt = GEN_WAIT;
            GEN_WAIT: if (!prng_done) state_nxt = CHECK;
            CHECK: begin
                if (accepted_draw)
                    state_nxt = REDUCE;
                else if (tries_q < TRY_MAX)
                    state_nxt = GEN_REQ;
                else
                    state_nxt = REDUCE;
            end
            REDUCE:   if (div_last) state_nxt = OUT;
            OUT:      if (val_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            tries_q  <= '0;
            div_cnt  <= '0;
            seed_q   <= SEED_INIT;
            val_q    <= '0;
            biased_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= (state == IDLE) && req && (bound == '0);

            // A same-cycle seed load lands before the first draw of the accepted request.
            if ((state == IDLE) && seed_load)
                seed_q <= seed_in;
            else if (capture)
                seed_q <= prng_rand;

            if (accept)
                tries_q <= '0;
            else if ((state_nxt == GEN_REQ) && (state != GEN_REQ))
                tries_q <= tries_q + 1'b1;

            if (div_active)
                div_cnt <= div_last ? 5'd0 : div_cnt + 5'd1;
            else
                div_cnt <= '0;

            if ((state == CHECK) && (state_nxt == REDUCE))
                biased_q <= !accepted_draw;

            if ((state == REDUCE) && div_last)
                val_q <= rem_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            n_q <= bound;

        if (capture)
            r_q <= prng_rand[30:0];

        if (accept) begin
            dvd_q <= RAND_MAX;
            rem_q <= '0;
        end else if (state == CHECK) begin
            dvd_q <= r_q;
            rem_q <= '0;
        end else if (div_active) begin
            dvd_q <= {dvd_q[29:0], 1'b0};
            rem_q <= rem_nxt;
        end

        if ((state == LIMIT) && div_last)
            limit_q <= RAND_MAX - rem_nxt;
    end

    assign busy       = (state != IDLE);
    assign prng_start = (state == GEN_REQ);
    assign val_valid  = (state == OUT);
    assign val        = val_q;
    assign val_biased = biased_q;
    assign err        = err_q;
    assign prng_seed  = seed_q;

endmodule

// File: tb/tb_prng_range.sv
// Directed bench for prng_range with a behavioural prng: table lookup on the seed, or a
// fixed stub value when stub_mode is set.
module tb_prng_range;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic [30:0] bound = '0;
    logic        seed_load = 1'b0;
    logic [31:0] seed_in = '0;
    logic        val_ready = 1'b0;
    logic        busy, val_valid, val_biased, err, prng_start;
    logic [30:0] val;
    logic [31:0] prng_seed;
    logic        prng_done;
    logic [31:0] prng_rand;

    int          n_chk = 0;
    int          n_err = 0;
    int          n_start = 0;
    logic [31:0] seed_log [0:63];
    logic        m_busy;
    logic [1:0]  m_cnt;
    logic [31:0] m_seed;
    logic        stub_mode = 1'b0;

    prng_range dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .bound      (bound),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .busy       (busy),
        .val        (val),
        .val_valid  (val_valid),
        .val_ready  (val_ready),
        .val_biased (val_biased),
        .err        (err),
        .prng_start (prng_start),
        .prng_seed  (prng_seed),
        .prng_done  (prng_done),
        .prng_rand  (prng_rand)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] prng_fn(input logic [31:0] s);
        if (stub_mode)
            return 32'h7FFFFFFE;
        case (s)
            32'h68493A1B: return 32'h1F85F81A;
            32'h7B818935: return 32'h755735EB;
            default:      return 32'h12345678;
        endcase
    endfunction

    // prng: three cycles after start, done pulses once; rand holds afterwards.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy    <= 1'b0;
            m_cnt     <= '0;
            m_seed    <= '0;
            prng_done <= 1'b0;
            prng_rand <= '0;
        end else if (prng_done) begin
            prng_done <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 2'd0) begin
                prng_done <= 1'b1;
                prng_rand <= prng_fn(m_seed);
                m_busy    <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 2'd1;
            end
        end else if (prng_start) begin
            m_busy             <= 1'b1;
            m_cnt              <= 2'd2;
            m_seed             <= prng_seed;
            seed_log[n_start[5:0]] <= prng_seed;
            n_start            <= n_start + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Drives one request from IDLE; returns once prng_start rises (lat = cycles after accept).
    task automatic issue(input logic [30:0] b, input logic ld, input logic [31:0] s,
                         output int lat);
        req = 1'b1; bound = b; seed_load = ld; seed_in = s;
        @(posedge clk); #1;
        req = 1'b0; seed_load = 1'b0;
        check("accept_busy", {31'd0, busy}, 32'd1);
        lat = 0;
        while (!prng_start && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait_out();
        int cnt;
        cnt = 0;
        while (!val_valid && cnt < 2000) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("reach_out", {31'd0, val_valid}, 32'd1);
    endtask

    task automatic ack();
        val_ready = 1'b1;
        @(posedge clk); #1;
        val_ready = 1'b0;
        check("ack_valid_low", {31'd0, val_valid}, 32'd0);
        check("ack_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        int base;
        logic        stable;
        logic [30:0] v0;

        repeat (3) @(posedge clk); #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_val_valid", {31'd0, val_valid}, 32'd0);
        check("rst_val", {1'b0, val}, 32'd0);
        check("rst_biased", {31'd0, val_biased}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_start", {31'd0, prng_start}, 32'd0);
        check("rst_seed", prng_seed, 32'h68493A1B);

        // req held high across reset release: not taken on the first edge
        req = 1'b1; bound = 31'h1000; rst = 1'b1;
        @(posedge clk); #1;
        check("release_edge1_busy", {31'd0, busy}, 32'd0);
        lat = 0;
        while (!busy && lat < 4) begin
            @(posedge clk); #1;
            lat++;
        end
        req = 1'b0;
        check("release_accept", {31'd0, busy}, 32'd1);
        wait_out();
        check("release_val", {1'b0, val}, 32'h81A);
        ack();

        // seed load and req in the same cycle, single accepted draw
        base = n_start;
        issue(31'h1000, 1'b1, 32'h68493A1B, lat);
        check("t1_limit_latency", lat, 31);
        wait_out();
        check("t1_draws", n_start - base, 1);
        check("t1_seed_used", seed_log[base[5:0]], 32'h68493A1B);
        check("t1_val", {1'b0, val}, 32'h81A);
        check("t1_biased", {31'd0, val_biased}, 32'd0);
        check("t1_seed_end", prng_seed, 32'h1F85F81A);
        ack();

        // first draw rejected, second accepted
        base = n_start;
        issue(31'h40000001, 1'b1, 32'h7B818935, lat);
        wait_out();
        check("t2_draws", n_start - base, 2);
        check("t2_seed0", seed_log[base[5:0]], 32'h7B818935);
        check("t2_seed1", seed_log[(base + 1) % 64], 32'h755735EB);
        check("t2_val", {1'b0, val}, 32'h12345678);
        check("t2_val_lt_n", {31'd0, (val < 31'h40000001)}, 32'd1);
        check("t2_biased", {31'd0, val_biased}, 32'd0);
        ack();

        // every draw rejected: tries exhausted
        stub_mode = 1'b1;
        base = n_start;
        issue(31'h40000001, 1'b0, 32'h0, lat);
        wait_out();
        check("t3_draws", n_start - base, 16);
        check("t3_val", {1'b0, val}, 32'h3FFFFFFD);
        check("t3_biased", {31'd0, val_biased}, 32'd1);

        // consumer stalls 20 cycles; req and seed_load in the window are ignored
        stable = 1'b1;
        v0 = val;
        base = n_start;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                req = 1'b1; bound = 31'h1000; seed_load = 1'b1; seed_in = 32'h11111111;
            end
            if (i == 6) begin
                req = 1'b0; seed_load = 1'b0;
            end
            @(posedge clk); #1;
            if (val !== v0 || val_valid !== 1'b1)
                stable = 1'b0;
        end
        check("stall_stable", {31'd0, stable}, 32'd1);
        check("stall_no_draw", n_start - base, 0);
        check("stall_seed_kept", prng_seed, 32'h7FFFFFFE);
        ack();
        stub_mode = 1'b0;

        // bound of zero
        base = n_start;
        req = 1'b1; bound = '0;
        @(posedge clk); #1;
        req = 1'b0;
        check("zero_err", {31'd0, err}, 32'd1);
        check("zero_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check("zero_err_pulse", {31'd0, err}, 32'd0);
        check("zero_busy2", {31'd0, busy}, 32'd0);
        check("zero_no_draw", n_start - base, 0);

        // reset asserted while requesting a draw
        issue(31'h1000, 1'b0, 32'h0, lat);
        check("gen_req_reached", {31'd0, prng_start}, 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_start", {31'd0, prng_start}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_seed", prng_seed, 32'h68493A1B);
        check("midrst_val", {1'b0, val}, 32'd0);
        check("midrst_biased", {31'd0, val_biased}, 32'd0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk); #1;

        // N = 1 is an ordinary request
        base = n_start;
        issue(31'd1, 1'b0, 32'h0, lat);
        check("n1_latency", lat, 31);
        wait_out();
        check("n1_draws", n_start - base, 1);
        check("n1_val", {1'b0, val}, 32'd0);
        check("n1_biased", {31'd0, val_biased}, 32'd0);
        ack();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/prng_range.md
PRNG_RANGE -- requirements
Module: prng_range

Interface
REQ-001 Parameter SEED_INIT, default 32'h68493A1B, value loaded into the seed-chain register at reset.
REQ-002 Parameter MAX_TRIES, default 16, maximum number of prng draws per request before the rejection loop gives up.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 req  in  1  request one bounded value; accepted only in IDLE.
REQ-006 bound  in  31  N, the exclusive upper limit; result is in [0, N-1]; sampled on the accept cycle.
REQ-007 seed_load  in  1  in IDLE, loads seed_in into the seed-chain register; ignored when busy.
REQ-008 seed_in  in  32  seed value for seed_load.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 val  out  31  bounded result; stable while val_valid is high.
REQ-011 val_valid  out  1  result available; held until val_ready.
REQ-012 val_ready  in  1  consumer accepts val when high with val_valid.
REQ-013 val_biased  out  1  qualifies val; high when MAX_TRIES was exhausted.
REQ-014 err  out  1  one-cycle pulse when a request is accepted with bound == 0.
REQ-015 prng_start  out  1  drives the prng start input.
REQ-016 prng_seed  out  32  drives the prng seed input; always equals the seed-chain register.
REQ-017 prng_done  in  1  prng done output.
REQ-018 prng_rand  in  32  prng rand output; only bits [30:0] are used.

Function
REQ-019 FSM states: IDLE, LIMIT, GEN_REQ, GEN_WAIT, CHECK, REDUCE, OUT.
REQ-020 In IDLE, req=1 with bound!=0 latches N=bound, clears the try counter, and moves to LIMIT; with bound==0 it pulses err and stays in IDLE.
REQ-021 In IDLE, if req and seed_load occur in the same cycle, the seed load applies first, so the new seed is used for the first draw.
REQ-022 LIMIT: 31-cycle restoring division computes R = (2^31-1) mod N; limit = (2^31-1) - R, width 31 bits; then go to GEN_REQ.
REQ-023 GEN_REQ: prng_start=1; the try counter increments on entry; on prng_done=1 go to GEN_WAIT.
REQ-024 GEN_WAIT: prng_start=0; on the first cycle with prng_done=0, capture r=prng_rand[30:0], load the seed-chain register with the full 32-bit prng_rand, and go to CHECK.
REQ-025 CHECK (1 cycle): if r < limit, go to REDUCE with val_biased=0.
REQ-026 CHECK, rejection with tries < MAX_TRIES: go to GEN_REQ.
REQ-027 CHECK, rejection with tries == MAX_TRIES: go to REDUCE with val_biased=1.
REQ-028 REDUCE: 31-cycle restoring division computes val = r mod N using the same divider datapath as LIMIT; then go to OUT.
REQ-029 OUT: val_valid=1; on val_ready=1 go to IDLE, with val_valid low the next cycle.
REQ-030 Fixed latency: LIMIT 31 cycles, CHECK 1 cycle, REDUCE 31 cycles; only the prng phases are variable.
REQ-031 req, bound, seed_load and seed_in are ignored outside IDLE.
REQ-032 N=1 needs no special case: it yields val=0 after exactly one draw.

Reset
REQ-033 Asynchronous assertion of rst (low) immediately forces: state=IDLE, busy=0, val_valid=0, val=0, val_biased=0, err=0, prng_start=0, seed-chain register=SEED_INIT, try counter=0.
REQ-034 Reset mid-operation abandons any in-flight prng handshake; there is no resume.
REQ-035 Deassertion is synchronised to clk; the first req is accepted no earlier than the second clk edge after rst rises.

Verification
REQ-036 Real prng, seed_load 32'h68493A1B, req with bound 32'h1000 -> exactly one prng_start pulse with prng_seed=32'h68493A1B; val=31'h81A, val_biased=0; seed register ends at 32'h1F85F81A.
REQ-037 Real prng, seed_load 32'h7B818935, bound 31'h40000001 -> first draw 32'h755735EB is rejected; second prng_start has prng_seed=32'h755735EB; the final val is < 31'h40000001.
REQ-038 Stub prng always returning 32'h7FFFFFFE, bound 31'h40000001 -> exactly 16 draws; val=31'h3FFFFFFD, val_biased=1.
REQ-039 req with bound=0 -> err high for one cycle; busy stays 0; no prng_start.
REQ-040 Hold val_ready=0 for 20 cycles in OUT -> val and val_valid stay constant; a req pulse in that window is ignored.
REQ-041 Assert rst low during GEN_REQ -> prng_start=0 in the same cycle; busy=0; prng_seed=32'h68493A1B.
